// File: rtl/player_input_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | input_arb_pkg : shared constants and state types for player_input_arbiter |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package input_arb_pkg;

   // Bit positions in the 8-bit {coin,start2,start1,fire,U,D,L,R} pad word
   localparam int CTRL_R      = 0;
   localparam int CTRL_L      = 1;
   localparam int CTRL_D      = 2;
   localparam int CTRL_U      = 3;
   localparam int CTRL_FIRE   = 4;
   localparam int CTRL_START1 = 5;
   localparam int CTRL_START2 = 6;
   localparam int CTRL_COIN   = 7;

   typedef enum logic [0:0] {
      SETTLE = 1'b0,
      RUN    = 1'b1
   } main_state_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } coin_state_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/player_input_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | player_input_arbiter_if : pad inputs and player outputs of the arbiter     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface player_input_arbiter_if;
   logic       db_ena;
   logic       db_two;
   logic [7:0] usb0;
   logic [7:0] usb1;
   logic [7:0] db1;
   logic [7:0] db2;
   logic       db1_menu;
   logic [6:0] p0_ctrl;
   logic [6:0] p1_ctrl;
   logic       coin_pulse;
   logic       osd_req;
   logic       settling;

   modport master (
      output db_ena, db_two, usb0, usb1, db1, db2, db1_menu,
      input  p0_ctrl, p1_ctrl, coin_pulse, osd_req, settling
   );

   modport slave (
      input  db_ena, db_two, usb0, usb1, db1, db2, db1_menu,
      output p0_ctrl, p1_ctrl, coin_pulse, osd_req, settling
   );
endinterface
`default_nettype wire

// File: rtl/player_input_arbiter_coin_pulse_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | coin_pulse_gen : coin edge -> fixed-width pulse, min gap, one pending edge |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module coin_pulse_gen
   import input_arb_pkg::*;
#(
   parameter int COIN_PULSE = 600000,
   parameter int COIN_GAP   = 600000
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic i_enable,
   input  wire logic i_abort,
   input  wire logic i_coin,
   output logic      o_pulse
);
   localparam int CNT_W = $clog2(max2(COIN_PULSE, COIN_GAP)) + 1;
   localparam logic [CNT_W-1:0] c_pulse_last = CNT_W'(COIN_PULSE - 1);
   localparam logic [CNT_W-1:0] c_gap_last   = CNT_W'(COIN_GAP - 1);

   coin_state_t      r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_pend, w_pend_nxt;
   logic             r_coin_q;
   logic             r_pulse;
   logic             w_rise;

   assign w_rise  = i_enable & i_coin & ~r_coin_q;
   assign o_pulse = r_pulse;

   // A pending edge is served by passing through IDLE, so the low time is COIN_GAP+1
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pend_nxt  = r_pend;
      if (i_abort) begin
         w_state_nxt = IDLE;
         w_cnt_nxt   = '0;
         w_pend_nxt  = 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (r_pend || w_rise) begin
                  w_state_nxt = PULSE;
                  w_cnt_nxt   = '0;
                  w_pend_nxt  = 1'b0;
               end
            end
            PULSE: begin
               if (w_rise) w_pend_nxt = 1'b1;
               if (r_cnt == c_pulse_last) begin
                  w_state_nxt = GAP;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            GAP: begin
               if (w_rise) w_pend_nxt = 1'b1;
               if (r_cnt == c_gap_last) begin
                  w_state_nxt = IDLE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_pend   <= 1'b0;
         r_coin_q <= 1'b0;
         r_pulse  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_pend   <= w_pend_nxt;
         r_coin_q <= i_coin;
         r_pulse  <= (w_state_nxt == PULSE);
      end
   end

endmodule
`default_nettype wire

// File: rtl/player_input_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | player_input_arbiter : pad source select, settle mask, coin and OSD combo  |
// | Rev 1.0 - optional combo detector enabled by INPUT_ARB_OSD_COMBO_EN        |
// +----------------------------------------------------------------------------+
module player_input_arbiter
   import input_arb_pkg::*;
#(
   parameter int SETTLE_CYCLES = 120000,
   parameter int COIN_PULSE    = 600000,
   parameter int COIN_GAP      = 600000,
   parameter int COMBO_CYCLES  = 6000000
) (
   input  wire logic             clk_sys,
   input  wire logic             RESET,
   player_input_arbiter_if.slave bus
);
   localparam int CNT_W = $clog2(max2(max2(SETTLE_CYCLES, COIN_PULSE),
                                      max2(COIN_GAP, COMBO_CYCLES))) + 1;
   localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [6:0]       c_p1_keep     = 7'b0011111;

   logic             r_db_ena, r_db_two;
   logic [7:0]       r_usb0, r_usb1, r_db1, r_db2;
   logic [1:0]       r_cfg_q;
   main_state_t      r_state, w_state_nxt;
   logic [CNT_W-1:0] r_settle_cnt, w_settle_nxt;
   logic [6:0]       r_p0, r_p1, w_p0_nxt, w_p1_nxt;
   logic [7:0]       w_src0, w_src1;
   logic             w_cfg_chg, w_enter_settle, w_coin, w_start1_mask, w_coin_pulse;

   always_comb begin
      w_src0 = r_usb0;
      w_src1 = r_usb1;
      if (r_db_ena) begin
         w_src0 = r_db1;
         w_src1 = r_db_two ? r_db2 : r_usb0;
      end
   end

   assign w_coin    = w_src0[CTRL_COIN] | w_src1[CTRL_COIN];
   assign w_cfg_chg = ({r_db_ena, r_db_two} != r_cfg_q);

   always_comb begin
      w_state_nxt    = r_state;
      w_settle_nxt   = r_settle_cnt;
      w_enter_settle = 1'b0;
      case (r_state)
         SETTLE: begin
            if (r_settle_cnt == c_settle_last) begin
               w_state_nxt  = RUN;
               w_settle_nxt = '0;
            end else begin
               w_settle_nxt = r_settle_cnt + CNT_W'(1);
            end
         end
         RUN: begin
            if (w_cfg_chg) begin
               w_state_nxt    = SETTLE;
               w_settle_nxt   = '0;
               w_enter_settle = 1'b1;
            end
         end
         default: begin
            w_state_nxt  = SETTLE;
            w_settle_nxt = '0;
         end
      endcase

      // Outputs are zeroed on the same edge the FSM enters SETTLE
      w_p0_nxt = '0;
      w_p1_nxt = '0;
      if (w_state_nxt == RUN) begin
         w_p0_nxt              = w_src0[6:0];
         w_p0_nxt[CTRL_START1] = w_src0[CTRL_START1] & ~w_start1_mask;
         w_p1_nxt              = w_src1[6:0] & c_p1_keep;
      end
   end

   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         r_db_ena     <= 1'b0;
         r_db_two     <= 1'b0;
         r_usb0       <= '0;
         r_usb1       <= '0;
         r_db1        <= '0;
         r_db2        <= '0;
         r_cfg_q      <= '0;
         r_state      <= SETTLE;
         r_settle_cnt <= '0;
         r_p0         <= '0;
         r_p1         <= '0;
      end else begin
         r_db_ena     <= bus.db_ena;
         r_db_two     <= bus.db_two;
         r_usb0       <= bus.usb0;
         r_usb1       <= bus.usb1;
         r_db1        <= bus.db1;
         r_db2        <= bus.db2;
         r_cfg_q      <= {r_db_ena, r_db_two};
         r_state      <= w_state_nxt;
         r_settle_cnt <= w_settle_nxt;
         r_p0         <= w_p0_nxt;
         r_p1         <= w_p1_nxt;
      end
   end

`ifdef INPUT_ARB_OSD_COMBO_EN
   localparam logic [CNT_W-1:0] c_combo_last = CNT_W'(COMBO_CYCLES - 1);

   logic             r_db1_menu, r_osd_req, w_combo_hold;
   logic [CNT_W-1:0] r_combo_cnt;

   assign w_combo_hold  = (r_state == RUN) & r_db_ena & r_db1[CTRL_START1] & r_db1_menu;
   assign w_start1_mask = w_combo_hold | r_osd_req;
   assign bus.osd_req   = r_osd_req;

   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         r_db1_menu  <= 1'b0;
         r_combo_cnt <= '0;
         r_osd_req   <= 1'b0;
      end else begin
         r_db1_menu <= bus.db1_menu;
         if (!w_combo_hold) begin
            r_combo_cnt <= '0;
            r_osd_req   <= 1'b0;
         end else if (r_combo_cnt == c_combo_last) begin
            r_osd_req <= 1'b1;
         end else begin
            r_combo_cnt <= r_combo_cnt + CNT_W'(1);
         end
      end
   end
`else
   assign w_start1_mask = 1'b0;
   assign bus.osd_req   = 1'b0;
`endif

   coin_pulse_gen #(
      .COIN_PULSE (COIN_PULSE),
      .COIN_GAP   (COIN_GAP)
   ) u_coin (
      .clk      (clk_sys),
      .rst      (RESET),
      .i_enable (r_state == RUN),
      .i_abort  (w_enter_settle),
      .i_coin   (w_coin),
      .o_pulse  (w_coin_pulse)
   );

   assign bus.p0_ctrl    = r_p0;
   assign bus.p1_ctrl    = r_p1;
   assign bus.coin_pulse = w_coin_pulse;
   assign bus.settling   = (r_state == SETTLE);

endmodule
`default_nettype wire

// File: tb/tb_player_input_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_player_input_arbiter : directed self-checking bench for the arbiter     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_player_input_arbiter;
`ifdef INPUT_ARB_OSD_COMBO_EN
   localparam bit c_combo = 1'b1;
`else
   localparam bit c_combo = 1'b0;
`endif

   logic clk_sys = 1'b0;
   logic RESET;
   int   n_checks = 0;
   int   n_errors = 0;

   player_input_arbiter_if bus();

   player_input_arbiter #(
      .SETTLE_CYCLES (8),
      .COIN_PULSE    (4),
      .COIN_GAP      (6),
      .COMBO_CYCLES  (16)
   ) u_dut (
      .clk_sys (clk_sys),
      .RESET   (RESET),
      .bus     (bus)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // drv[i] is the usb0 coin bit sampled at edge i; exp[i] is coin_pulse after edge i
   task automatic coin_vector(input string tag, input logic [31:0] drv, input logic [31:0] exp);
      for (int i = 0; i < 32; i++) begin
         bus.usb0 = {drv[i], 7'h02};
         tick();
         check_value($sformatf("%s[%0d]", tag, i), 32'(bus.coin_pulse), 32'(exp[i]));
      end
   endtask

   initial begin
      RESET        = 1'b1;
      bus.db_ena   = 1'b0;
      bus.db_two   = 1'b0;
      bus.usb0     = 8'h10;
      bus.usb1     = 8'h00;
      bus.db1      = 8'h00;
      bus.db2      = 8'h00;
      bus.db1_menu = 1'b0;
      repeat (3) tick();
      check_value("rst_p0", 32'(bus.p0_ctrl), 32'h0);
      check_value("rst_p1", 32'(bus.p1_ctrl), 32'h0);
      check_value("rst_coin", 32'(bus.coin_pulse), 32'h0);
      check_value("rst_osd", 32'(bus.osd_req), 32'h0);
      check_value("rst_settling", 32'(bus.settling), 32'h1);

      // Power-up settle window
      RESET = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         tick();
         check_value("settle_mask_p0", 32'(bus.p0_ctrl), 32'h0);
         check_value("settle_flag", 32'(bus.settling), 32'h1);
      end
      tick();
      check_value("run_p0_usb0", 32'(bus.p0_ctrl), 32'h10);
      check_value("run_p1_usb1", 32'(bus.p1_ctrl), 32'h0);
      check_value("run_settling", 32'(bus.settling), 32'h0);

      // Switch to single DB pad: p0=db1, p1=usb0
      bus.db_ena = 1'b1;
      bus.db1    = 8'h21;
      bus.usb0   = 8'h02;
      tick();
      check_value("cfg_old_p0", 32'(bus.p0_ctrl), 32'h10);
      check_value("cfg_old_settling", 32'(bus.settling), 32'h0);
      tick();
      check_value("cfg_settling", 32'(bus.settling), 32'h1);
      check_value("cfg_p0_zero", 32'(bus.p0_ctrl), 32'h0);
      for (int i = 3; i <= 9; i++) begin
         tick();
         check_value("cfg_mask_p0", 32'(bus.p0_ctrl), 32'h0);
      end
      tick();
      check_value("db1_p0", 32'(bus.p0_ctrl), 32'h21);
      check_value("db1_p1_usb0", 32'(bus.p1_ctrl), 32'h02);
      check_value("db1_settling", 32'(bus.settling), 32'h0);

      // Coin sequences on usb0 (player 1 source)
      coin_vector("coin_hold", 32'h000F_FFFF, 32'h0000_001E);
      coin_vector("coin_pend_gap", 32'h0000_0029, 32'h0000_F01E);
      coin_vector("coin_pend_pulse", 32'h0000_0015, 32'h0000_F01E);

      // db_two toggle during a pulse, with a coin edge on the same cycle
      bus.db2 = 8'h0C;
      bus.db1 = 8'hA1;
      tick();
      check_value("abort_pre", 32'(bus.coin_pulse), 32'h0);
      bus.db1 = 8'h21;
      tick();
      check_value("abort_pulse1", 32'(bus.coin_pulse), 32'h1);
      bus.db1    = 8'hA1;
      bus.db_two = 1'b1;
      tick();
      check_value("abort_pulse2", 32'(bus.coin_pulse), 32'h1);
      check_value("abort_run", 32'(bus.settling), 32'h0);
      bus.db1 = 8'h21;
      tick();
      check_value("abort_drop", 32'(bus.coin_pulse), 32'h0);
      check_value("abort_settling", 32'(bus.settling), 32'h1);
      check_value("abort_p0", 32'(bus.p0_ctrl), 32'h0);
      for (int i = 4; i <= 10; i++) begin
         tick();
         check_value("abort_settle_coin", 32'(bus.coin_pulse), 32'h0);
         check_value("abort_settle_flag", 32'(bus.settling), 32'h1);
      end
      tick();
      check_value("two_settling", 32'(bus.settling), 32'h0);
      check_value("two_p0_db1", 32'(bus.p0_ctrl), 32'h21);
      check_value("two_p1_db2", 32'(bus.p1_ctrl), 32'h0C);
      for (int i = 0; i < 8; i++) begin
         tick();
         check_value("no_pending", 32'(bus.coin_pulse), 32'h0);
      end

      // Start+Menu combo on DB pad 1 (db1 start1 already held)
      bus.db1_menu = 1'b1;
      tick();
      tick();
      check_value("combo_start1_mask", 32'(bus.p0_ctrl), c_combo ? 32'h01 : 32'h21);
      repeat (14) tick();
      check_value("combo_early", 32'(bus.osd_req), 32'h0);
      tick();
      check_value("combo_osd", 32'(bus.osd_req), 32'(c_combo));
      check_value("combo_osd_p0", 32'(bus.p0_ctrl), c_combo ? 32'h01 : 32'h21);
      bus.db1_menu = 1'b0;
      tick();
      check_value("combo_release_hold", 32'(bus.osd_req), 32'(c_combo));
      tick();
      check_value("combo_release", 32'(bus.osd_req), 32'h0);
      tick();
      check_value("combo_p0_restore", 32'(bus.p0_ctrl), 32'h21);

      // Asynchronous reset in the middle of a pulse
      bus.db1 = 8'hA1;
      tick();
      bus.db1 = 8'h21;
      tick();
      check_value("arst_pulse", 32'(bus.coin_pulse), 32'h1);
      #2;
      RESET = 1'b1;
      #1;
      check_value("arst_coin", 32'(bus.coin_pulse), 32'h0);
      check_value("arst_p0", 32'(bus.p0_ctrl), 32'h0);
      check_value("arst_settling", 32'(bus.settling), 32'h1);
      #10;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
